// File: rtl/register_file_vector_param.sv
// Parametrised vector register file: 2 combinational read ports, 1 lane-masked write port, bulk-clear sequencer.
// Define VRF_BYPASS_EN to forward an accepted same-edge write onto matching read ports.
module register_file_vector_param #(
    parameter int unsigned N      = 256,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned LANE_W = 32,
    parameter int unsigned AW     = 5,
    parameter int unsigned BASE   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [AW-1:0]         VA1,
    input  logic [AW-1:0]         VA2,
    input  logic [AW-1:0]         VA3,
    input  logic [N-1:0]          VWD3,
    input  logic                  VWE3,
    input  logic [N/LANE_W-1:0]   VWM3,
    input  logic                  clr_req,
    output logic [N-1:0]          VRD1,
    output logic [N-1:0]          VRD2,
    output logic                  busy,
    output logic                  wr_drop
);

    localparam int unsigned LANES = N / LANE_W;
    localparam int unsigned IW    = $clog2(DEPTH);
    localparam int unsigned LO    = BASE;
    localparam int unsigned HI    = BASE + DEPTH;

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t         r_state, w_state_nxt;
    logic [IW-1:0]  r_ptr, w_ptr_nxt;
    logic [N-1:0]   r_mem [DEPTH];
    logic           r_wr_drop;
    logic [N-1:0]   w_lane_mask;
    logic           w_wr_ok;
    logic [IW-1:0]  w_wr_idx;
    logic [N-1:0]   w_wr_merged;

    function automatic logic f_valid(input logic [AW-1:0] a);
        return (32'(a) >= LO) && (32'(a) < HI);
    endfunction

    function automatic logic [IW-1:0] f_idx(input logic [AW-1:0] a);
        return IW'(a - AW'(BASE));
    endfunction

    always_comb begin
        w_lane_mask = '0;
        for (int unsigned i = 0; i < LANES; i++)
            w_lane_mask[i*LANE_W +: LANE_W] = {LANE_W{VWM3[i]}};
    end

    // A clear request wins over a same-edge write, so the write is dropped.
    assign w_wr_ok     = VWE3 && f_valid(VA3) && (r_state == S_IDLE) && !clr_req;
    assign w_wr_idx    = f_idx(VA3);
    assign w_wr_merged = (VWD3 & w_lane_mask) | (r_mem[w_wr_idx] & ~w_lane_mask);

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            S_IDLE: begin
                if (clr_req) begin
                    w_state_nxt = S_CLEAR;
                    w_ptr_nxt   = '0;
                end
            end
            S_CLEAR: begin
                w_ptr_nxt = r_ptr + IW'(1);
                if (r_ptr == IW'(DEPTH - 1))
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_wr_drop <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_wr_drop <= VWE3 && !w_wr_ok;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
        end else if (r_state == S_CLEAR) begin
            r_mem[r_ptr] <= '0;
        end else if (w_wr_ok) begin
            r_mem[w_wr_idx] <= w_wr_merged;
        end
    end

    always_comb begin
        VRD1 = f_valid(VA1) ? r_mem[f_idx(VA1)] : '0;
        VRD2 = f_valid(VA2) ? r_mem[f_idx(VA2)] : '0;
`ifdef VRF_BYPASS_EN
        if (w_wr_ok && (VA1 == VA3))
            VRD1 = w_wr_merged;
        if (w_wr_ok && (VA2 == VA3))
            VRD2 = w_wr_merged;
`endif
    end

    assign busy    = (r_state == S_CLEAR);
    assign wr_drop = r_wr_drop;

endmodule

// File: doc/register_file_vector_param.md
# register_file_vector_param

Parametrised vector register file for the SIMD AES datapath decode stage. It generalises the fixed 8 x 256-bit vector file to configurable width, depth, lane granularity and address base. It adds per-lane write masking, optional write-to-read forwarding, and a multi-cycle bulk-clear sequencer with a busy flag. Two combinational read ports and one clocked write port feed the vector execute stage.

## Interface
- N, 256: register width in bits.
- DEPTH, 8: number of vector registers; power of two, 2..16.
- LANE_W, 32: lane width for write masking; N % LANE_W == 0; LANES = N/LANE_W.
- AW, 5: address width.
- BASE, 16: address of register 0 (5'b10000 = $v0).

- clk  in  1  clock, rising-edge active.
- rst  in  1  asynchronous, active-low reset.
- VA1  in  AW  read address, port 1.
- VA2  in  AW  read address, port 2.
- VA3  in  AW  write address.
- VWD3  in  N  write data.
- VWE3  in  1  write enable.
- VWM3  in  LANES  per-lane write mask; bit i covers bits [i*LANE_W +: LANE_W].
- clr_req  in  1  bulk-clear request, sampled on the edge.
- VRD1  out  N  read data, port 1.
- VRD2  out  N  read data, port 2.
- busy  out  1  clear sequence in progress.
- wr_drop  out  1  registered one-cycle flag: last-edge write was discarded.

## Operation
- Valid address: BASE <= A < BASE+DEPTH. Index = A - BASE, truncated to log2(DEPTH) bits.
- Reads are combinational. A valid address returns reg[index]. An invalid address returns all zeros.
- A write occurs at the rising edge when VWE3=1, VA3 is valid, state=IDLE and clr_req=0. Only lanes with VWM3[i]=1 update; other lanes hold.
- VWM3 all zeros with VWE3=1 is a legal no-op and does not set wr_drop.
- wr_drop is set to 1 for one cycle after an edge where VWE3=1 and the write was rejected. Reasons: invalid VA3, busy=1, or clr_req=1 in IDLE. Otherwise wr_drop is 0.
- FSM states: IDLE and CLEAR.
  - IDLE -> CLEAR on an edge with clr_req=1; ptr <= 0, busy <= 1.
  - In CLEAR, each edge zeroes all lanes of reg[ptr] and increments ptr.
  - The edge that zeroes reg[DEPTH-1] returns the FSM to IDLE with busy <= 0.
  - clr_req in CLEAR is ignored (no restart).
- Reads stay live during CLEAR: already-cleared registers read 0, pending ones read their old value.
- Reset: asynchronous on rst=0. All registers are set to 0, state to IDLE, ptr to 0, busy to 0, wr_drop to 0. VRD1/VRD2 therefore read 0. Reset asserted mid-CLEAR aborts the sequence immediately.

## Timing
- Read latency is 0 cycles (combinational from the array, or from the bypass when enabled).
- Write latency: data is visible on the stored path after the next rising edge.
- Clear sequence: busy is high for exactly DEPTH cycles, starting at the edge after clr_req is sampled. The write port is dead for DEPTH+1 edges including the request edge.
- wr_drop is valid one cycle after the offending edge.

## Configuration
- VRF_BYPASS_EN defined:
  - Forwarding applies when a write will be accepted at the coming edge and VAx == VA3.
  - In that case VRDx = (VWD3 & lane_mask) | (reg[index] & ~lane_mask), where lane_mask expands VWM3 to N bits.
  - Forwarding is never applied while busy=1, or when clr_req=1 in IDLE.
- VRF_BYPASS_EN undefined: reads always return stored contents; same-cycle read-after-write returns the old value.

## Test plan
- Reset then read: pulse rst=0, then read VA1=5'b10000, VA2=5'b10111 -> VRD1=VRD2=0, busy=0, wr_drop=0.
- Masked write:
  - Step 1: VA3=5'b10110, VWD3=all 1s, VWM3=all 1s.
  - Step 2: VWD3=0, VWM3=8'b0000_0001.
  - Read VA1=5'b10110 -> all ones except bits [31:0] = 0.
- Invalid address: write VA3=5'b01011, VWE3=1 -> wr_drop=1 next cycle, no register changes; read VA1=5'b01001 -> VRD1=0.
- Bypass (build with VRF_BYPASS_EN): VA1=VA3=5'b10001, VWD3=256'h55, VWM3=all 1s, VWE3=1 -> VRD1=256'h55 in the same cycle. Without the macro, VRD1 shows the old value until the edge.
- Bulk clear:
  - Preload all 8 registers with nonzero data, then pulse clr_req.
  - busy stays high for 8 cycles; $v3 reads 0 after the 4th CLEAR edge while $v4 still shows its old value.
  - A write during busy sets wr_drop and is discarded; busy=0 after the sequence.
- Reset mid-clear: assert rst=0 during CLEAR cycle 3 -> busy=0 immediately, all registers 0, FSM back in IDLE; the next write is accepted.
